map_table: RTL and testbench

MAP_TABLE -- requirements
Module: map_table

---
 rtl/sys_defs.sv | 41 ++++
 rtl/map_table.sv | 102 ++++++++++
 tb/tb_map_table.sv | 131 +++++++++++++
 3 files changed

// File: rtl/sys_defs.sv
// Shared processor definitions: ROB tag width, map-table entry and packet types.
`ifndef ROB_IDX_LEN
`define ROB_IDX_LEN 5
`endif

package sys_defs;

   localparam int ROB_IDX_LEN  = `ROB_IDX_LEN;
   localparam int NUM_ARCH_REG = 32;
   localparam int AR_IDX_LEN   = $clog2(NUM_ARCH_REG);

   typedef struct packed {
      logic                   renamed;
      logic                   ready;
      logic [ROB_IDX_LEN-1:0] tag;
   } MT_ENTRY;

   typedef struct packed {
      logic                   valid;
      logic [AR_IDX_LEN-1:0]  dest;
      logic [ROB_IDX_LEN-1:0] tag;
   } ID_MT_PACKET;

   typedef struct packed {
      logic                   valid;
      logic [ROB_IDX_LEN-1:0] tag;
   } CDB_MT_PACKET;

   typedef struct packed {
      logic                   valid;
      logic [AR_IDX_LEN-1:0]  dest;
      logic [ROB_IDX_LEN-1:0] tag;
   } ROB_MT_PACKET;

   typedef struct packed {
      logic                   renamed;
      logic                   ready;
      logic [ROB_IDX_LEN-1:0] tag;
   } MT_RS_PACKET;

endpackage

// File: rtl/map_table.sv
// Register rename map table: arch reg -> in-flight ROB tag with ready tracking.
// Optional MT_CDB_FORWARD_EN: same-cycle CDB forwarding into the ready outputs.
`ifndef ROB_IDX_LEN
`define ROB_IDX_LEN 5
`endif

module map_table
   import sys_defs::*;
#(
   parameter int NUM_ARCH_REG = 32,
   parameter int TAG_W        = `ROB_IDX_LEN,
   localparam int IDX_W       = $clog2(NUM_ARCH_REG)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             dispatch_valid,
   input  logic [IDX_W-1:0] dispatch_dest,
   input  logic [TAG_W-1:0] dispatch_tag,
   input  logic [IDX_W-1:0] src1_idx,
   input  logic [IDX_W-1:0] src2_idx,
   input  logic             cdb_valid,
   input  logic [TAG_W-1:0] cdb_tag,
   input  logic             retire_valid,
   input  logic [IDX_W-1:0] retire_dest,
   input  logic [TAG_W-1:0] retire_tag,
   input  logic             squash,
   output logic             src1_renamed,
   output logic             src2_renamed,
   output logic [TAG_W-1:0] src1_tag,
   output logic [TAG_W-1:0] src2_tag,
   output logic             src1_ready,
   output logic             src2_ready
);

   // Entries are MT_ENTRY, so TAG_W is expected to equal ROB_IDX_LEN.
   MT_ENTRY      mt_q    [NUM_ARCH_REG];
   MT_ENTRY      mt_next [NUM_ARCH_REG];
   ID_MT_PACKET  id_pkt;
   CDB_MT_PACKET cdb_pkt;
   ROB_MT_PACKET rob_pkt;
   MT_RS_PACKET  rs1, rs2;
   MT_ENTRY      e1, e2;

   assign id_pkt  = '{valid: dispatch_valid, dest: dispatch_dest, tag: dispatch_tag};
   assign cdb_pkt = '{valid: cdb_valid, tag: cdb_tag};
   assign rob_pkt = '{valid: retire_valid, dest: retire_dest, tag: retire_tag};

   // NOTE: combinational blocks use blocking '=' with every output defaulted
   // first, so no latch is inferred; the register below uses '<=' only.
   always_comb begin
      mt_next = mt_q;
      // Entry 0 (x0) is never written, so it stays at its reset value.
      for (int i = 1; i < NUM_ARCH_REG; i++) begin
         if (cdb_pkt.valid && mt_q[i].renamed && mt_q[i].tag == cdb_pkt.tag)
            mt_next[i].ready = 1'b1;
         if (rob_pkt.valid && rob_pkt.dest == IDX_W'(i) &&
             mt_q[i].renamed && mt_q[i].tag == rob_pkt.tag) begin
            mt_next[i].renamed = 1'b0;
            mt_next[i].ready   = 1'b0;
         end
         // Applied last so a same-entry dispatch overrides both CDB and retire.
         if (id_pkt.valid && id_pkt.dest == IDX_W'(i))
            mt_next[i] = '{renamed: 1'b1, ready: 1'b0, tag: id_pkt.tag};
      end
      if (squash)
         mt_next = '{default: '0};
   end

   // NOTE: unlike a RAM, this table is reset: every renamed bit must read 0
   // immediately after reset, and reset dominates all same-cycle updates.
   always_ff @(posedge clock) begin
      if (!reset) mt_q <= '{default: '0};
      else        mt_q <= mt_next;
   end

   assign e1 = mt_q[src1_idx];
   assign e2 = mt_q[src2_idx];

   always_comb begin
      rs1         = '0;
      rs2         = '0;
      rs1.renamed = e1.renamed;
      rs2.renamed = e2.renamed;
      rs1.tag     = e1.renamed ? e1.tag : '0;
      rs2.tag     = e2.renamed ? e2.tag : '0;
`ifdef MT_CDB_FORWARD_EN
      rs1.ready   = e1.renamed & (e1.ready | (cdb_pkt.valid && e1.tag == cdb_pkt.tag));
      rs2.ready   = e2.renamed & (e2.ready | (cdb_pkt.valid && e2.tag == cdb_pkt.tag));
`else
      rs1.ready   = e1.renamed & e1.ready;
      rs2.ready   = e2.renamed & e2.ready;
`endif
   end

   assign src1_renamed = rs1.renamed;
   assign src1_ready   = rs1.ready;
   assign src1_tag     = rs1.tag;
   assign src2_renamed = rs2.renamed;
   assign src2_ready   = rs2.ready;
   assign src2_tag     = rs2.tag;

endmodule

// File: tb/tb_map_table.sv
// Self-checking bench for map_table: vector table plus expected-value scoreboard.
// Expectations follow MT_CDB_FORWARD_EN when it is defined for the build.
`timescale 1ns/1ps

module tb_map_table;
   import sys_defs::*;

   localparam int TW = ROB_IDX_LEN;
`ifdef MT_CDB_FORWARD_EN
   localparam logic FWD = 1'b1;
`else
   localparam logic FWD = 1'b0;
`endif

   typedef logic [TW+1:0] exp_t;   // {renamed, ready, tag}

   typedef struct {
      logic          rst_n;
      logic          dv;  logic [4:0] dd; logic [TW-1:0] dt;
      logic          cv;  logic [TW-1:0] ct;
      logic          rv;  logic [4:0] rd; logic [TW-1:0] rt;
      logic          sq;
      logic [4:0]    s1;  logic [4:0] s2;
      exp_t          e1;  exp_t e2;
   } vec_t;

   logic          clock = 1'b0;
   logic          reset;
   logic          dispatch_valid, cdb_valid, retire_valid, squash;
   logic [4:0]    dispatch_dest, retire_dest, src1_idx, src2_idx;
   logic [TW-1:0] dispatch_tag, cdb_tag, retire_tag;
   logic          src1_renamed, src2_renamed, src1_ready, src2_ready;
   logic [TW-1:0] src1_tag, src2_tag;

   int   tests_run = 0;
   int   tests_failed = 0;
   exp_t sb[$];
   vec_t vecs[19];
   vec_t hand[4];

   map_table dut (
      .clock(clock), .reset(reset),
      .dispatch_valid(dispatch_valid), .dispatch_dest(dispatch_dest), .dispatch_tag(dispatch_tag),
      .src1_idx(src1_idx), .src2_idx(src2_idx),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
      .retire_valid(retire_valid), .retire_dest(retire_dest), .retire_tag(retire_tag),
      .squash(squash),
      .src1_renamed(src1_renamed), .src2_renamed(src2_renamed),
      .src1_tag(src1_tag), .src2_tag(src2_tag),
      .src1_ready(src1_ready), .src2_ready(src2_ready)
   );

   always #5 clock = ~clock;

   function automatic exp_t ex(input logic ren, input logic rdy, input int tag);
      return {ren, rdy, TW'(tag)};
   endfunction

   task automatic check(input string name, input exp_t act, input exp_t exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got renamed=%b ready=%b tag=%0d, want renamed=%b ready=%b tag=%0d",
                  name, act[TW+1], act[TW], act[TW-1:0], exp[TW+1], exp[TW], exp[TW-1:0]);
      end
   endtask

   // Drive one cycle of stimulus at negedge, queue its expectations, then
   // compare the combinational lookups well before the next posedge.
   task automatic apply(input string tag_name, input vec_t v);
      @(negedge clock);
      reset = v.rst_n;
      dispatch_valid = v.dv; dispatch_dest = v.dd; dispatch_tag = v.dt;
      cdb_valid = v.cv; cdb_tag = v.ct;
      retire_valid = v.rv; retire_dest = v.rd; retire_tag = v.rt;
      squash = v.sq; src1_idx = v.s1; src2_idx = v.s2;
      sb.push_back(v.e1);
      sb.push_back(v.e2);
      #2;
      check({tag_name, "_src1"}, {src1_renamed, src1_ready, src1_tag}, sb.pop_front());
      check({tag_name, "_src2"}, {src2_renamed, src2_ready, src2_tag}, sb.pop_front());
   endtask

   initial begin
      exp_t z;
      z = ex(0, 0, 0);
      //          rst dv dd dt  cv ct  rv rd rt  sq s1 s2  e1                e2
      vecs[0]  = '{1, 0, 0, 0,  0, 0,  0, 0, 0,  0, 5, 3,  z,                z};
      vecs[1]  = '{1, 1, 3, 2,  0, 0,  0, 0, 0,  0, 3, 5,  z,                z};
      vecs[2]  = '{1, 0, 0, 0,  1, 2,  0, 0, 0,  0, 3, 0,  ex(1, FWD, 2),    z};
      vecs[3]  = '{1, 1, 3, 5,  0, 0,  0, 0, 0,  0, 3, 0,  ex(1, 1, 2),      z};
      vecs[4]  = '{1, 0, 0, 0,  0, 0,  1, 3, 2,  0, 3, 3,  ex(1, 0, 5),      ex(1, 0, 5)};
      vecs[5]  = '{1, 0, 0, 0,  0, 0,  1, 3, 5,  0, 3, 0,  ex(1, 0, 5),      z};
      vecs[6]  = '{1, 1, 1, 1,  0, 0,  0, 0, 0,  0, 3, 1,  z,                z};
      vecs[7]  = '{1, 1, 4, 3,  0, 0,  0, 0, 0,  0, 1, 4,  ex(1, 0, 1),      z};
      vecs[8]  = '{1, 1, 6, 4,  1, 1,  0, 0, 0,  1, 1, 4,  ex(1, FWD, 1),    ex(1, 0, 3)};
      vecs[9]  = '{1, 0, 0, 0,  0, 0,  0, 0, 0,  0, 1, 4,  z,                z};
      vecs[10] = '{1, 1, 0, 1,  0, 0,  0, 0, 0,  0, 6, 0,  z,                z};
      vecs[11] = '{1, 1, 7, 6,  0, 0,  0, 0, 0,  0, 0, 7,  z,                z};
      vecs[12] = '{1, 1, 7, 9,  0, 0,  1, 7, 6,  0, 7, 7,  ex(1, 0, 6),      ex(1, 0, 6)};
      vecs[13] = '{1, 1, 2, 7,  0, 0,  0, 0, 0,  0, 7, 2,  ex(1, 0, 9),      z};
      vecs[14] = '{1, 1, 5, 7,  1, 7,  0, 0, 0,  0, 2, 5,  ex(1, FWD, 7),    z};
      vecs[15] = '{1, 0, 0, 0,  0, 0,  0, 0, 0,  0, 2, 5,  ex(1, 1, 7),      ex(1, 0, 7)};
      vecs[16] = '{1, 0, 0, 0,  1, 7,  0, 0, 0,  0, 2, 5,  ex(1, 1, 7),      ex(1, FWD, 7)};
      vecs[17] = '{0, 1, 8, 3,  1, 7,  1, 2, 7,  1, 2, 5,  ex(1, 1, 7),      ex(1, 1, 7)};
      vecs[18] = '{1, 0, 0, 0,  0, 0,  0, 0, 0,  0, 8, 2,  z,                z};

      // Tag 31 wraps to 0; only an exact tag match may mark the entry ready.
      hand[0]  = '{1, 1, 10, 31, 0, 0,  0, 0, 0,  0, 10, 0, z,                z};
      hand[1]  = '{1, 0, 0,  0,  1, 0,  0, 0, 0,  0, 10, 0, ex(1, 0, 31),     z};
      hand[2]  = '{1, 0, 0,  0,  1, 31, 0, 0, 0,  0, 10, 0, ex(1, FWD, 31),   z};
      hand[3]  = '{1, 0, 0,  0,  0, 0,  1, 10, 0, 0, 10, 0, ex(1, 1, 31),     z};

      reset = 1'b0;
      dispatch_valid = 0; dispatch_dest = 0; dispatch_tag = 0;
      cdb_valid = 0; cdb_tag = 0; retire_valid = 0; retire_dest = 0; retire_tag = 0;
      squash = 0; src1_idx = 0; src2_idx = 0;
      repeat (2) @(posedge clock);

      for (int i = 0; i < 19; i++) apply($sformatf("vec%0d", i), vecs[i]);
      for (int i = 0; i < 4; i++)  apply($sformatf("wrap%0d", i), hand[i]);

      // Retire with a mismatched tag must leave the mapping in place.
      apply("wrap_after_retire", '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 10, 10,
                                   ex(1, 1, 31), ex(1, 1, 31)});

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
